// File: rtl/core_seq_ctrl.sv
// Job sequencer for one matrix-multiply core: clears the core, streams K operand
// tiles from the A/B buffers, waits out the core latency and hands off the result.
module core_seq_ctrl #(
    parameter int K_W      = 8,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [K_W-1:0] num_k,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           buf_rd_en,
    output logic [K_W-1:0] buf_rd_addr,
    input  logic           op_ready,
    output logic           core_reset,
    output logic           core_enable,
    output logic [1:0]     core_in_valid,
    output logic           res_valid,
    input  logic           res_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [K_W-1:0] k;
    logic [K_W-1:0] num_k_q;
    logic [3:0]     drain_cnt;
    logic           in_valid_q;
    logic           active;
    logic           last_read;
    logic           drain_end;

    assign active        = (state == CLEAR) || (state == ISSUE) ||
                           (state == DRAIN) || (state == WRITE);
    assign last_read     = (k == (num_k_q - K_W'(1)));
    // DRAIN also covers the final in_valid cycle, so it spans CORE_LAT+1 cycles.
    assign drain_end     = (drain_cnt == 4'(CORE_LAT));
    assign core_in_valid = {2{in_valid_q}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= '0;
            num_k_q    <= '0;
            drain_cnt  <= '0;
            in_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            in_valid_q <= buf_rd_en && !abort;
            case (state)
                IDLE: begin
                    if (start && (num_k != '0)) begin
                        num_k_q <= num_k;
                    end
                end
                CLEAR: begin
                    k         <= '0;
                    drain_cnt <= '0;
                end
                ISSUE: begin
                    if (op_ready && !last_read) begin
                        k <= k + K_W'(1);
                    end
                end
                DRAIN: begin
                    if (!drain_end) begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        done        = 1'b0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;
        core_reset  = 1'b0;
        res_valid   = 1'b0;
        busy        = active;
        core_enable = active;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_k != '0) ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                core_reset = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                buf_rd_addr = k;
                buf_rd_en   = op_ready;
                if (op_ready && last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over every other transition, including the result handshake.
        if (active && abort) begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl: timing of a basic job, stalls,
// backpressure, zero/max length, start while busy, abort and asynchronous reset.
module tb_core_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] num_k;
    logic       abort;
    logic       busy;
    logic       done;
    logic       buf_rd_en;
    logic [7:0] buf_rd_addr;
    logic       op_ready;
    logic       core_reset;
    logic       core_enable;
    logic [1:0] core_in_valid;
    logic       res_valid;
    logic       res_ready;

    int tests;
    int fails;

    core_seq_ctrl #(
        .K_W      (8),
        .CORE_LAT (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_k         (num_k),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .buf_rd_en     (buf_rd_en),
        .buf_rd_addr   (buf_rd_addr),
        .op_ready      (op_ready),
        .core_reset    (core_reset),
        .core_enable   (core_enable),
        .core_in_valid (core_in_valid),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units after it.
    task automatic apply_stimulus(input bit st, input logic [7:0] nk, input bit opr,
                                  input bit rr, input bit ab);
        @(posedge clk);
        #1;
        start     = st;
        num_k     = nk;
        op_ready  = opr;
        res_ready = rr;
        abort     = ab;
        #2;
    endtask

    task automatic check_output(input string tag, input int c,
                                input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic check_cycle(input int c, input bit cr, input bit re, input int addr,
                               input bit iv, input bit rv, input bit dn, input bit bz);
        check_output("core_reset", c, 32'(core_reset), 32'(cr));
        check_output("buf_rd_en", c, 32'(buf_rd_en), 32'(re));
        check_output("buf_rd_addr", c, 32'(buf_rd_addr), addr);
        check_output("core_in_valid", c, 32'(core_in_valid), iv ? 32'd3 : 32'd0);
        check_output("res_valid", c, 32'(res_valid), 32'(rv));
        check_output("done", c, 32'(done), 32'(dn));
        check_output("busy", c, 32'(busy), 32'(bz));
        check_output("core_enable", c, 32'(core_enable), 32'(bz));
    endtask

    task automatic run_basic();
        for (int c = 0; c <= 12; c++) begin
            apply_stimulus(c == 0, 8'd4, 1'b1, 1'b1, 1'b0);
            check_cycle(c, c == 1, (c >= 2) && (c <= 5), ((c >= 2) && (c <= 5)) ? c - 2 : 0,
                        (c >= 3) && (c <= 6), c == 9, c == 10, (c >= 1) && (c <= 9));
        end
    endtask

    initial begin
        int rd_count;
        int iv_count;
        int done_count;
        int done_cyc;
        int last_addr;
        int exp_addr;

        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        num_k     = 8'd0;
        abort     = 1'b0;
        op_ready  = 1'b1;
        res_ready = 1'b1;

        #12;
        check_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        $display("[TB] basic job num_k=4");
        run_basic();

        $display("[TB] operand stall at cycles 3-4");
        for (int c = 0; c <= 13; c++) begin
            apply_stimulus(c == 0, 8'd4, !((c == 3) || (c == 4)), 1'b1, 1'b0);
            case (c)
                2:         exp_addr = 0;
                3, 4, 5:   exp_addr = 1;
                6:         exp_addr = 2;
                7:         exp_addr = 3;
                default:   exp_addr = 0;
            endcase
            check_cycle(c, c == 1, (c == 2) || ((c >= 5) && (c <= 7)), exp_addr,
                        (c == 3) || ((c >= 6) && (c <= 8)), c == 11, c == 12,
                        (c >= 1) && (c <= 11));
        end

        $display("[TB] result backpressure for 3 cycles");
        for (int c = 0; c <= 14; c++) begin
            apply_stimulus(c == 0, 8'd4, 1'b1, !((c >= 9) && (c <= 11)), 1'b0);
            check_cycle(c, c == 1, (c >= 2) && (c <= 5), ((c >= 2) && (c <= 5)) ? c - 2 : 0,
                        (c >= 3) && (c <= 6), (c >= 9) && (c <= 12), c == 13,
                        (c >= 1) && (c <= 12));
        end

        $display("[TB] zero-length job");
        for (int c = 0; c <= 3; c++) begin
            apply_stimulus(c == 0, 8'd0, 1'b1, 1'b1, 1'b0);
            check_cycle(c, 0, 0, 0, 0, 0, c == 1, 0);
        end

        $display("[TB] max-length job num_k=255");
        rd_count  = 0;
        iv_count  = 0;
        done_cyc  = -1;
        last_addr = -1;
        for (int c = 0; c <= 265; c++) begin
            apply_stimulus(c == 0, 8'd255, 1'b1, 1'b1, 1'b0);
            if (buf_rd_en) begin
                check_output("max_addr", c, 32'(buf_rd_addr), rd_count);
                last_addr = int'(buf_rd_addr);
                rd_count++;
            end
            if (core_in_valid == 2'b11) iv_count++;
            if (done) done_cyc = c;
        end
        check_output("max_reads", 265, rd_count, 255);
        check_output("max_in_valid", 265, iv_count, 255);
        check_output("max_last_addr", 265, last_addr, 254);
        check_output("max_done_cycle", 265, done_cyc, 261);

        $display("[TB] start pulse during DRAIN");
        done_count = 0;
        done_cyc   = -1;
        for (int c = 0; c <= 14; c++) begin
            apply_stimulus((c == 0) || (c == 7), (c == 7) ? 8'd2 : 8'd4, 1'b1, 1'b1, 1'b0);
            if (done) begin
                done_count++;
                done_cyc = c;
            end
            if (c >= 11) check_output("busy_after_ignored_start", c, 32'(busy), 32'd0);
        end
        check_output("ignored_start_done_count", 14, done_count, 1);
        check_output("ignored_start_done_cycle", 14, done_cyc, 10);

        $display("[TB] abort on the second read");
        for (int c = 0; c <= 10; c++) begin
            apply_stimulus(c == 0, 8'd4, 1'b1, 1'b1, c == 3);
            if (c <= 3) begin
                check_cycle(c, c == 1, c >= 2, (c >= 2) ? c - 2 : 0, c == 3, 0, 0, c >= 1);
            end else begin
                check_cycle(c, 0, 0, 0, 0, 0, 0, 0);
            end
        end

        $display("[TB] asynchronous reset during ISSUE");
        for (int c = 0; c <= 3; c++) begin
            apply_stimulus(c == 0, 8'd4, 1'b1, 1'b1, 1'b0);
        end
        check_output("pre_reset_rd_en", 3, 32'(buf_rd_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_cycle(3, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        check_cycle(4, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        $display("[TB] clean job after reset");
        run_basic();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
